// File: rtl/eth_pcs_params.sv
// Shared 64b/66b PCS definitions: sync-header codes, lock FSM state type
// and the sync-header validity helper used by the receive block-lock logic.
package eth_pcs_params;

  localparam int                    W_SYNC_HDR    = 2;
  localparam logic [W_SYNC_HDR-1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [W_SYNC_HDR-1:0] SYNC_HDR_CTRL = 2'b10;

  typedef enum logic {
    TEST_SH = 1'b0,
    SLIP    = 1'b1
  } lock_state_t;

  // Only the two transition patterns are legal sync headers; 00 and 11 are errors.
  function automatic logic sync_hdr_ok(input logic [W_SYNC_HDR-1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_ber_mon.sv
// High bit-error-rate monitor for the 64b/66b receive path.
// Counts headers and invalid headers over a BER_WINDOW-header window; raises
// hi_ber once BER_INVLD_MAX invalid headers are seen inside a window and drops
// it only when a whole window completes below that count. Held cleared while
// block lock is absent.
// Ports:
//   clk        in   clock
//   rst        in   async active-high reset
//   hdr_valid  in   a header is presented this cycle
//   hdr_ok     in   the presented header is a legal sync header
//   block_lock in   registered block-lock state from the lock FSM
//   hi_ber     out  high bit-error-rate flag (0 whenever block_lock is 0)
module eth_pcs_ber_mon #(
  parameter int BER_WINDOW    = 19531,
  parameter int BER_INVLD_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic hdr_valid,
  input  logic hdr_ok,
  input  logic block_lock,
  output logic hi_ber
);

  localparam int WIN_W = $clog2(BER_WINDOW + 1);
  localparam int INV_W = $clog2(BER_INVLD_MAX + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW);
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(BER_INVLD_MAX);

  logic [WIN_W-1:0] win_cnt_p1;
  logic [INV_W-1:0] inv_cnt_p1;
  logic             hi_ber_p1;

  logic [WIN_W-1:0] win_next_p0;
  logic [INV_W-1:0] inv_next_p0;

  // ---- stage p0: next-count computation for the presented header ----
  always_comb begin
    win_next_p0 = win_cnt_p1 + WIN_W'(1);
    inv_next_p0 = inv_cnt_p1;
    if (!hdr_ok && (inv_cnt_p1 != INV_LAST)) begin
      inv_next_p0 = inv_cnt_p1 + INV_W'(1);
    end
  end

  // ---- stage p1: window counters and flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_p1 <= '0;
      inv_cnt_p1 <= '0;
      hi_ber_p1  <= 1'b0;
    end else if (!block_lock) begin
      win_cnt_p1 <= '0;
      inv_cnt_p1 <= '0;
      hi_ber_p1  <= 1'b0;
    end else if (hdr_valid) begin
      if (inv_next_p0 == INV_LAST) begin
        hi_ber_p1 <= 1'b1;
      end
      if (win_next_p0 == WIN_LAST) begin
        win_cnt_p1 <= '0;
        inv_cnt_p1 <= '0;
        if (inv_next_p0 != INV_LAST) begin
          hi_ber_p1 <= 1'b0;
        end
      end else begin
        win_cnt_p1 <= win_next_p0;
        inv_cnt_p1 <= inv_next_p0;
      end
    end
  end

  assign hi_ber = hi_ber_p1 & block_lock;

endmodule

// File: rtl/eth_pcs_rx_block_lock.sv
// Receive-side 64b/66b block-lock FSM. Judges each sync header from the RX
// gearbox, declares and drops block lock, and requests one-bit gearbox slips
// until block alignment is found.
// Optional feature macro: PCS_HI_BER_EN (instantiates eth_pcs_ber_mon;
// without it o_hi_ber is tied 0).
// Ports:
//   i_rx_clk     in   clock
//   i_rx_reset   in   async active-high reset
//   i_hdr_valid  in   i_hdr carries one block's sync header this cycle
//   i_hdr        in   2-bit sync header
//   o_slip       out  one-cycle pulse: gearbox shifts alignment by one bit
//   o_block_lock out  block lock achieved
//   o_hdr_err    out  pulse: the previous cycle's counted header was invalid
//   o_hi_ber     out  high bit-error-rate flag
module eth_pcs_rx_block_lock
  import eth_pcs_params::*;
#(
  parameter int SH_CNT_MAX    = 64,
  parameter int SH_INVLD_MAX  = 16,
  parameter int SLIP_WAIT     = 4,
  parameter int BER_WINDOW    = 19531,
  parameter int BER_INVLD_MAX = 16
) (
  input  logic                  i_rx_clk,
  input  logic                  i_rx_reset,
  input  logic                  i_hdr_valid,
  input  logic [W_SYNC_HDR-1:0] i_hdr,
  output logic                  o_slip,
  output logic                  o_block_lock,
  output logic                  o_hdr_err,
  output logic                  o_hi_ber
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  if (SLIP_WAIT < 1) begin : g_bad_slip_wait
    $error("SLIP_WAIT must be at least 1");
  end
  if (SH_INVLD_MAX < 1 || SH_INVLD_MAX > SH_CNT_MAX) begin : g_bad_invld_max
    $error("SH_INVLD_MAX must lie in 1..SH_CNT_MAX");
  end
  if (BER_INVLD_MAX < 1 || BER_WINDOW < BER_INVLD_MAX) begin : g_bad_ber
    $error("BER_INVLD_MAX must lie in 1..BER_WINDOW");
  end

  lock_state_t       state_p1;
  logic [SH_W-1:0]   sh_cnt_p1;
  logic [INV_W-1:0]  invld_cnt_p1;
  logic [WAIT_W-1:0] wait_cnt_p1;
  logic              block_lock_p1;
  logic              slip_p1;
  logic              hdr_err_p1;

  logic              vld_p0;
  logic              hdr_ok_p0;
  logic [SH_W-1:0]   sh_next_p0;
  logic [INV_W-1:0]  invld_next_p0;

  // ---- stage p0: header judgement and next counts ----
  assign vld_p0        = i_hdr_valid;
  assign hdr_ok_p0     = sync_hdr_ok(i_hdr);
  assign sh_next_p0    = sh_cnt_p1 + SH_W'(1);
  assign invld_next_p0 = invld_cnt_p1 + INV_W'(1);

  // ---- stage p1: lock FSM and registered outputs ----
  always_ff @(posedge i_rx_clk or posedge i_rx_reset) begin
    if (i_rx_reset) begin
      state_p1      <= TEST_SH;
      sh_cnt_p1     <= '0;
      invld_cnt_p1  <= '0;
      wait_cnt_p1   <= '0;
      block_lock_p1 <= 1'b0;
      slip_p1       <= 1'b0;
      hdr_err_p1    <= 1'b0;
    end else begin
      slip_p1    <= 1'b0;
      hdr_err_p1 <= 1'b0;
      case (state_p1)
        TEST_SH: begin
          if (vld_p0) begin
            if (hdr_ok_p0) begin
              if (sh_next_p0 == SH_LAST) begin
                sh_cnt_p1    <= '0;
                invld_cnt_p1 <= '0;
                if (invld_cnt_p1 == '0) begin
                  block_lock_p1 <= 1'b1;
                end
              end else begin
                sh_cnt_p1 <= sh_next_p0;
              end
            end else begin
              hdr_err_p1 <= 1'b1;
              // Slip takes priority over a coincident window end.
              if (!block_lock_p1 || (invld_next_p0 == INV_LAST)) begin
                state_p1      <= SLIP;
                block_lock_p1 <= 1'b0;
                slip_p1       <= 1'b1;
                sh_cnt_p1     <= '0;
                invld_cnt_p1  <= '0;
                wait_cnt_p1   <= '0;
              end else if (sh_next_p0 == SH_LAST) begin
                sh_cnt_p1    <= '0;
                invld_cnt_p1 <= '0;
              end else begin
                sh_cnt_p1    <= sh_next_p0;
                invld_cnt_p1 <= invld_next_p0;
              end
            end
          end
        end
        SLIP: begin
          if (wait_cnt_p1 == WAIT_LAST) begin
            state_p1     <= TEST_SH;
            wait_cnt_p1  <= '0;
            sh_cnt_p1    <= '0;
            invld_cnt_p1 <= '0;
          end else begin
            wait_cnt_p1 <= wait_cnt_p1 + WAIT_W'(1);
          end
        end
      endcase
    end
  end

  assign o_slip       = slip_p1;
  assign o_block_lock = block_lock_p1;
  assign o_hdr_err    = hdr_err_p1;

`ifdef PCS_HI_BER_EN
  eth_pcs_ber_mon #(
    .BER_WINDOW    (BER_WINDOW),
    .BER_INVLD_MAX (BER_INVLD_MAX)
  ) u_ber_mon (
    .clk        (i_rx_clk),
    .rst        (i_rx_reset),
    .hdr_valid  (vld_p0),
    .hdr_ok     (hdr_ok_p0),
    .block_lock (block_lock_p1),
    .hi_ber     (o_hi_ber)
  );
`else
  assign o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Directed bench for eth_pcs_rx_block_lock: lock acquisition, unlocked slip
// with settle window, locked error tolerance, slip-over-window-end priority,
// one-bit-shifted loopback alignment, async reset and (with PCS_HI_BER_EN)
// the high-BER flag.
module tb_eth_pcs_rx_block_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hdr_valid = 1'b0;
  logic [1:0] hdr = 2'b00;
  logic       slip;
  logic       block_lock;
  logic       hdr_err;
  logic       hi_ber;

  int n_chk  = 0;
  int n_pass = 0;
  int slip_seen, err_seen, ber_seen, drop_seen;

  logic [65:0] blk [0:3199];

  eth_pcs_rx_block_lock dut (
    .i_rx_clk     (clk),
    .i_rx_reset   (rst),
    .i_hdr_valid  (hdr_valid),
    .i_hdr        (hdr),
    .o_slip       (slip),
    .o_block_lock (block_lock),
    .o_hdr_err    (hdr_err),
    .o_hi_ber     (hi_ber)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic clear_seen();
    slip_seen = 0; err_seen = 0; ber_seen = 0; drop_seen = 0;
  endtask

  // Present one header, then sample just after the deciding edge.
  task automatic send(input logic [1:0] h);
    @(negedge clk);
    hdr_valid = 1'b1;
    hdr = h;
    @(posedge clk);
    #1;
    slip_seen += int'(slip);
    err_seen  += int'(hdr_err);
    ber_seen  += int'(hi_ber);
    drop_seen += int'(!block_lock);
  endtask

  task automatic send_n(input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) send(h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hdr_valid = 1'b0;
      hdr = 2'b00;
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    hdr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq({tag, "_slip"}, slip, 0);
    check_eq({tag, "_lock"}, block_lock, 0);
    check_eq({tag, "_err"}, hdr_err, 0);
    check_eq({tag, "_ber"}, hi_ber, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic bit_at(input int pos);
    logic [65:0] b;
    b = blk[pos / 66];
    return b[65 - (pos % 66)];
  endfunction

  function automatic logic [1:0] hdr_at(input int pos);
    return {bit_at(pos), bit_at(pos + 1)};
  endfunction

  initial begin
    int off, c, nslip, last_slip, min_gap;
    logic [1:0] h;

    for (int i = 0; i < 3200; i++) begin
      h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      blk[i] = {h, $urandom(), $urandom()};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_slip", slip, 0);
    check_eq("rst_lock", block_lock, 0);
    check_eq("rst_err", hdr_err, 0);
    check_eq("rst_ber", hi_ber, 0);
    @(negedge clk);
    rst = 1'b0;

    // Lock acquisition with idle gaps mid-window
    clear_seen();
    send_n(2'b01, 32);
    idle(3);
    send_n(2'b01, 31);
    check_eq("t1_lock_63", block_lock, 0);
    send(2'b01);
    check_eq("t1_lock_64", block_lock, 1);
    check_eq("t1_no_slip", slip_seen, 0);
    check_eq("t1_no_err", err_seen, 0);

    // Unlocked single error slips; settle window ignores headers
    do_reset("t2_rst");
    send(2'b01);
    send(2'b01);
    send(2'b11);
    check_eq("t2_err", hdr_err, 1);
    check_eq("t2_slip", slip, 1);
    check_eq("t2_lock", block_lock, 0);
    clear_seen();
    send_n(2'b11, 4);
    check_eq("t2_ignored_err", err_seen, 0);
    check_eq("t2_slip_width", slip_seen, 0);
    send_n(2'b01, 63);
    check_eq("t2_lock_63", block_lock, 0);
    send(2'b01);
    check_eq("t2_lock_64", block_lock, 1);

    // Locked: 15 errors in a window tolerated, 16 drop lock
    clear_seen();
    for (int i = 0; i < 64; i++) send((i < 60 && i % 4 == 0) ? 2'b11 : 2'b01);
    check_eq("t3_w15_lock_held", drop_seen, 0);
    check_eq("t3_w15_no_slip", slip_seen, 0);
    check_eq("t3_w15_errs", err_seen, 15);
    clear_seen();
    for (int i = 0; i < 45; i++) send((i % 3 == 0) ? 2'b11 : 2'b01);
    check_eq("t3_w16_lock_before", drop_seen, 0);
    check_eq("t3_w16_no_slip_before", slip_seen, 0);
    send(2'b11);
    check_eq("t3_w16_slip", slip, 1);
    check_eq("t3_w16_lock", block_lock, 0);
    check_eq("t3_w16_err", hdr_err, 1);
    send_n(2'b01, 4);
    send_n(2'b01, 64);
    check_eq("t3_relock", block_lock, 1);

    // 16th error on the window's last header: slip beats window end
    clear_seen();
    for (int i = 0; i < 63; i++) send((i < 60 && i % 4 == 0) ? 2'b11 : 2'b01);
    check_eq("t4_lock_63", block_lock, 1);
    send(2'b00);
    check_eq("t4_slip", slip, 1);
    check_eq("t4_lock", block_lock, 0);

    // Loopback with 1-bit PMA shift: gearbox model slips until aligned
    do_reset("t5_rst");
    off = 1; c = 0; nslip = 0; last_slip = -1000; min_gap = 1000;
    while (!block_lock && c < 3000) begin
      send(hdr_at(c * 66 + off));
      if (slip) begin
        if (c - last_slip < min_gap) min_gap = c - last_slip;
        last_slip = c;
        nslip++;
        off++;
      end
      c++;
    end
    check_eq("t5_locked", block_lock, 1);
    check_eq("t5_slips", nslip, 65);
    check_eq("t5_aligned", off % 66, 0);
    check_eq("t5_slip_spacing", min_gap >= 5, 1);
    clear_seen();
    for (int i = 0; i < 64; i++) begin
      send(hdr_at(c * 66 + off));
      c++;
    end
    check_eq("t5_clean_after_lock", err_seen, 0);
    check_eq("t5_lock_held", drop_seen, 0);

    // Reset during a slip pulse, then during lock
    do_reset("t6_pre");
    send(2'b10);
    send(2'b00);
    check_eq("t6_slip_up", slip, 1);
    do_reset("t6_midslip");
    send_n(2'b10, 63);
    check_eq("t6_lock_63", block_lock, 0);
    send(2'b10);
    check_eq("t6_lock_64", block_lock, 1);
    do_reset("t6_locked");

`ifdef PCS_HI_BER_EN
    // High BER: 16 errors within the BER window while lock holds
    send_n(2'b01, 64);
    check_eq("t7_lock", block_lock, 1);
    clear_seen();
    for (int i = 0; i < 120; i++) send((i % 8 == 0) ? 2'b11 : 2'b01);
    check_eq("t7_ber_15", hi_ber, 0);
    check_eq("t7_lock_held", drop_seen, 0);
    send(2'b11);
    check_eq("t7_ber_16", hi_ber, 1);
    send_n(2'b01, 19531 - 121);
    check_eq("t7_ber_after_bad_window", hi_ber, 1);
    send_n(2'b01, 19530);
    check_eq("t7_ber_before_clean_end", hi_ber, 1);
    send(2'b01);
    check_eq("t7_ber_clean_window", hi_ber, 0);
    for (int i = 0; i < 64; i++) send((i % 8 == 0) ? 2'b11 : 2'b01);
    do_reset("t7_midwindow");
`else
    check_eq("t7_ber_tied_low", ber_seen, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_block_lock.md
Name: eth_pcs_rx_block_lock

Overview:
- Receive-side 64b/66b block-lock FSM (IEEE 802.3 cl.49 lock_fsm); counterpart of the TX PCS sync-header insertion.
- Sits between the RX gearbox (supplies one 2-bit sync header per 66-bit block) and the descrambler/decoder.
- Judges header validity, declares/drops block lock, and requests one-bit slips from the gearbox until alignment is found.
- This is the logic that recovers from the PMA_DATA_SHIFT loopback offset.

Parameters:
- SH_CNT_MAX, 64, headers per test window.
- SH_INVLD_MAX, 16, invalid headers in one window that force a slip while locked.
- SLIP_WAIT, 4, cycles headers are ignored after a slip (gearbox settle); must be >=1.
- BER_WINDOW, 19531, headers per 125 us BER window (PCS_HI_BER_EN only).
- BER_INVLD_MAX, 16, invalid headers per BER window that raise hi_ber (PCS_HI_BER_EN only).

Ports:
- i_rx_clk  in  1  clock.
- i_rx_reset  in  1  async active-high reset.
- i_hdr_valid  in  1  i_hdr is valid this cycle (one block).
- i_hdr  in  2  sync header of the current block.
- o_slip  out  1  one-cycle pulse: gearbox shifts alignment by 1 bit.
- o_block_lock  out  1  block lock achieved.
- o_hdr_err  out  1  registered pulse: the previous cycle's valid header was invalid.
- o_hi_ber  out  1  high bit-error-rate flag (constant 0 without PCS_HI_BER_EN).

Behaviour:
- Header validity: 2'b01 or 2'b10 valid; 2'b00 / 2'b11 invalid.
- Reset values: all outputs 0; state TEST_SH; counters 0.
- Counters: sh_cnt 0..SH_CNT_MAX (clog2(SH_CNT_MAX+1) bits); invld_cnt 0..SH_INVLD_MAX. No wrap; both reload explicitly.
- States: TEST_SH, SLIP.
- TEST_SH, i_hdr_valid=0: hold all counters and state.
- TEST_SH, valid header: sh_cnt++.
  - If sh_cnt reaches SH_CNT_MAX with invld_cnt==0: set o_block_lock=1 on the same edge and reload both counters to 0.
  - If sh_cnt reaches SH_CNT_MAX with invld_cnt>0: reload counters only; lock unchanged.
- TEST_SH, invalid header: sh_cnt++, invld_cnt++, o_hdr_err=1 next cycle. Then, in priority order:
  - o_block_lock==0, or invld_cnt reaches SH_INVLD_MAX: go to SLIP; o_block_lock<=0; o_slip=1 for exactly one cycle; counters cleared.
  - Else, if sh_cnt reaches SH_CNT_MAX: reload counters; stay locked.
- Simultaneous window end and SH_INVLD_MAX on the same header: slip wins.
- Latency: every decision appears at the outputs one clock after the deciding i_hdr_valid cycle.
- SLIP: a wait counter runs SLIP_WAIT cycles; i_hdr_valid is ignored (not counted, no o_hdr_err). At expiry go to TEST_SH with clean counters. No second slip can occur before SLIP_WAIT elapses.
- Unlocked: any single invalid header causes a slip. Locked: only SH_INVLD_MAX invalid headers within one SH_CNT_MAX window drop lock.
- Reset asserted mid-operation (including mid-slip): immediate return to reset values; a slip pulse in flight is truncated.

Optional Feature:
- Macro: PCS_HI_BER_EN.
- Defined: an independent BER monitor counts headers while i_hdr_valid (including during SLIP) and invalid headers within a BER_WINDOW-header window.
  - If the invalid count reaches BER_INVLD_MAX inside the window, o_hi_ber=1 on the next edge and stays set until a full window completes with fewer than BER_INVLD_MAX invalid headers.
  - Both counters restart at each window end.
  - o_hi_ber is forced 0 while o_block_lock==0 and the monitor holds in reset.
- Undefined: no BER counters are synthesised; o_hi_ber tied 0.

Decomposition:
- eth_pcs_params gains: SYNC_HDR_DATA=2'b01, SYNC_HDR_CTRL=2'b10, W_SYNC_HDR=2, and a lock_state_t enum {TEST_SH, SLIP}.
- Sub-module eth_pcs_ber_mon, instantiated only under PCS_HI_BER_EN; the lock FSM stays in the top module.

Test Plan:
- Reset, then 64 consecutive 2'b01 headers -> o_block_lock rises exactly one cycle after the 64th; o_slip never pulses.
- Unlocked, header sequence 01,01,11 -> o_hdr_err and o_slip pulse one cycle after the 11. The next 4 headers are ignored (no o_hdr_err); after 64 clean headers o_block_lock=1.
- Locked, 15 invalid headers spread over one 64-header window -> lock holds. 16 invalid headers in one window -> o_block_lock falls with a one-cycle o_slip on the 16th.
- Locked, 63rd header of a window valid and 64th header 2'b00 with invld_cnt=15 -> slip and lock loss (slip beats window end).
- Loopback with a 1-bit PMA shift -> o_slip pulses until aligned (at most 65 slips), then lock; MAC frames received intact after lock.
- PCS_HI_BER_EN defined, locked, 16 invalid headers within 19531 headers (while lock held) -> o_hi_ber=1. One clean window -> o_hi_ber=0. Assert i_rx_reset mid-window -> all outputs 0 immediately.
